// File: rtl/led_pwm_driver.sv
// led_pwm_driver: frame-aligned PWM brightness, per-LED blink and
// registered LED drive, configured through a 4-word Avalon-MM slave.
//
// Ports:
//   clk, reset_n     system clock, async active-low reset
//   pattern_in       LED on/off pattern from the PIO (same clock)
//   address          Avalon-MM word address (0 DUTY, 1 MASK,
//                    2 BLINK_HALF, 3 STATUS)
//   chipselect       Avalon-MM select
//   write_n          Avalon-MM write strobe, active-low
//   writedata        Avalon-MM write data
//   readdata         combinational read data, zero wait states
//   led_out          registered LED drive, active-high
//   pwm_sync         one-clock pulse at each PWM frame start
module led_pwm_driver #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_DIV  = 16,
  parameter int BLINK_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                pwm_sync
);

  localparam int DW =
    (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(PWM_DIV - 1);

  logic [7:0]          duty;
  logic [NUM_LEDS-1:0] blink_mask;
  logic [BLINK_W-1:0]  blink_half;

  logic [DW-1:0]       div_cnt;
  logic [7:0]          pwm_cnt;
  logic [7:0]          duty_act;
  logic [NUM_LEDS-1:0] pat_act;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink_phase;

  logic wr_en;
  logic wr_duty;
  logic wr_mask;
  logic wr_half;
  logic step;
  logic frame_wrap;
  logic pwm_on;
  logic [NUM_LEDS-1:0] led_nxt;

  logic unused_wd;
  assign unused_wd = ^writedata;

  assign wr_en   = chipselect & ~write_n;
  assign wr_duty = wr_en & (address == 2'd0);
  assign wr_mask = wr_en & (address == 2'd1);
  assign wr_half = wr_en & (address == 2'd2);

  assign step       = (div_cnt == DIV_LAST);
  assign frame_wrap = step & (pwm_cnt == 8'hFF);

  // 0xFF is treated as fully on so a full-scale duty
  // never shows the one dark step of pwm_cnt==255.
  assign pwm_on = (duty_act == 8'hFF) ? 1'b1 :
                  (pwm_cnt < duty_act);

  assign led_nxt = pat_act
                 & {NUM_LEDS{pwm_on}}
                 & (~blink_mask | {NUM_LEDS{blink_phase}});

  // Config registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty       <= 8'hFF;
      blink_mask <= '0;
      blink_half <= '0;
    end else begin
      if (wr_duty)
        duty <= writedata[7:0];
      if (wr_mask)
        blink_mask <= writedata[NUM_LEDS-1:0];
      if (wr_half)
        blink_half <= writedata[BLINK_W-1:0];
    end
  end

  // Prescaler and PWM step counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      if (step) begin
        div_cnt <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Frame shadows: mid-frame changes wait for the boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_act <= 8'hFF;
      pat_act  <= '0;
      pwm_sync <= 1'b0;
    end else begin
      pwm_sync <= frame_wrap;
      if (frame_wrap) begin
        duty_act <= duty;
        pat_act  <= pattern_in;
      end
    end
  end

  // Blink timer, counted in frames. A BLINK_HALF write
  // restarts the cycle in the visible phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wr_half) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_wrap) begin
      if (blink_half == '0) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == blink_half - 1'b1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // LED drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      led_out <= '0;
    else
      led_out <= led_nxt;
  end

  // Read mux
  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata[7:0] = duty;
      2'd1: readdata[NUM_LEDS-1:0] = blink_mask;
      2'd2: readdata[BLINK_W-1:0] = blink_half;
      2'd3: begin
        readdata[0]    = blink_phase;
        readdata[15:8] = pwm_cnt;
      end
    endcase
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: scoreboard bench for led_pwm_driver,
// PWM_DIV=2, NUM_LEDS=8, BLINK_W=16.
module tb_led_pwm_driver;

  localparam int DIV   = 2;
  localparam int FRAME = 256 * DIV;

  logic        clk;
  logic        reset_n;
  logic [7:0]  pattern_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led_out;
  logic        pwm_sync;

  led_pwm_driver #(
    .NUM_LEDS(8),
    .PWM_DIV (DIV),
    .BLINK_W (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pattern_in(pattern_in),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .led_out   (led_out),
    .pwm_sync  (pwm_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic       sync;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference model: frame position counted in clocks
  int          m_pos;
  logic [7:0]  m_duty, m_dact, m_pact, m_mask;
  logic [15:0] m_half, m_bcnt;
  logic        m_phase;

  always @(posedge clk or negedge reset_n) begin
    int   pwm;
    logic on;
    exp_t e;
    if (!reset_n) begin
      m_pos   = 0;
      m_duty  = 8'hFF;
      m_dact  = 8'hFF;
      m_pact  = 8'h00;
      m_mask  = 8'h00;
      m_half  = 16'h0;
      m_bcnt  = 16'h0;
      m_phase = 1'b1;
      sb.delete();
    end else begin
      pwm = m_pos / DIV;
      on  = (m_dact == 8'hFF) || (pwm < int'(m_dact));
      e.led  = m_pact & {8{on}} & (~m_mask | {8{m_phase}});
      e.sync = (m_pos == FRAME - 1);
      sb.push_back(e);
      if (m_pos == FRAME - 1) begin
        m_dact = m_duty;
        m_pact = pattern_in;
        if (m_half == 0) begin
          m_bcnt  = 0;
          m_phase = 1'b1;
        end else if (m_bcnt + 1 == m_half) begin
          m_bcnt  = 0;
          m_phase = ~m_phase;
        end else begin
          m_bcnt = m_bcnt + 1;
        end
      end
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_duty = writedata[7:0];
          2'd1: m_mask = writedata[7:0];
          2'd2: begin
            m_half  = writedata[15:0];
            m_bcnt  = 0;
            m_phase = 1'b1;
          end
          default: ;
        endcase
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("led_out", {24'h0, led_out}, {24'h0, e.led});
      chk("pwm_sync", {31'h0, pwm_sync}, {31'h0, e.sync});
    end
  end

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string tag,
                    input logic [1:0] a,
                    input logic [31:0] exp);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    #1;
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic rd_status(input string tag);
    logic [31:0] exp;
    @(negedge clk);
    address    = 2'd3;
    chipselect = 1'b1;
    #1;
    exp = {16'h0, 8'(m_pos / DIV), 7'h0, m_phase};
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic wait_sync(input string tag);
    bit seen = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      @(negedge clk);
      if (pwm_sync) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  task automatic wait_cnt(input string tag, input int t);
    bit seen = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      @(negedge clk);
      if (m_pos / DIV == t) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  initial begin
    int n;
    bit seen;
    reset_n    = 1'b0;
    pattern_in = 8'h00;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;

    repeat (5) @(negedge clk);
    chk("rst_led", {24'h0, led_out}, 32'h0);
    chk("rst_sync", {31'h0, pwm_sync}, 32'h0);
    rd("rst_duty", 2'd0, 32'hFF);
    rd("rst_status", 2'd3, 32'h1);

    // release, measure first frame start
    @(negedge clk);
    reset_n    = 1'b1;
    pattern_in = 8'hA5;
    n    = 0;
    seen = 0;
    for (int i = 0; i < FRAME + 50; i++) begin
      @(negedge clk);
      n++;
      if (pwm_sync) begin
        seen = 1;
        break;
      end
    end
    chk("first_sync_seen", {31'h0, seen}, 32'h1);
    chk("first_sync_clks", n, FRAME);

    // full brightness frame
    wait_sync("full_a5");
    wait_cnt("full_mid", 128);
    chk("full_a5_led", {24'h0, led_out}, 32'hA5);

    // half duty
    wr(2'd0, 32'h80);
    pattern_in = 8'hFF;
    wait_sync("half_s1");
    wait_sync("half_s2");
    wait_cnt("half_c50", 50);
    rd_status("status_50");
    wait_cnt("half_c200", 200);
    rd_status("status_200");

    // frame-aligned update
    wr(2'd0, 32'h40);
    pattern_in = 8'h0F;
    wait_sync("upd_s1");
    wait_sync("upd_s2");
    wait_cnt("upd_c30", 30);
    wr(2'd0, 32'hC0);
    pattern_in = 8'hF0;
    wait_cnt("upd_c40", 40);
    chk("old_frame_led", {24'h0, led_out}, 32'h0F);
    wait_sync("upd_s3");
    wait_cnt("upd_c60", 60);
    pattern_in = 8'h00;
    @(negedge clk);
    pattern_in = 8'hF0;
    wait_cnt("upd_c150", 150);
    chk("new_frame_led", {24'h0, led_out}, 32'hF0);
    wait_sync("upd_s4");
    wait_sync("upd_s5");

    // blink
    wr(2'd0, 32'hFF);
    pattern_in = 8'hFF;
    wr(2'd1, 32'h0F);
    wr(2'd2, 32'h3);
    rd("blink_half_rd", 2'd2, 32'h3);
    rd("blink_mask_rd", 2'd1, 32'h0F);
    for (int f = 0; f < 8; f++) wait_sync("blink_run");
    seen = 0;
    for (int i = 0; i < 8 * FRAME; i++) begin
      @(negedge clk);
      if (!m_phase) begin
        seen = 1;
        break;
      end
    end
    chk("blink_off_seen", {31'h0, seen}, 32'h1);
    wait_cnt("blink_c80", 80);
    chk("blink_off_led", {24'h0, led_out}, 32'hF0);
    wr(2'd2, 32'h3);
    rd_status("blink_rewrite");
    chk("blink_rewrite_led", {24'h0, led_out}, 32'hFF);
    for (int f = 0; f < 4; f++) wait_sync("blink_run2");

    // reset mid-frame
    wr(2'd1, 32'h0);
    wait_sync("rst_s");
    wait_cnt("rst_c100", 100);
    chk("pre_rst_led", {24'h0, led_out}, 32'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_led", {24'h0, led_out}, 32'h0);
    chk("async_rst_sync", {31'h0, pwm_sync}, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd("post_rst_status", 2'd3, 32'h1);
    rd("post_rst_duty", 2'd0, 32'hFF);
    wait_sync("post_rst_sync");
    wait_sync("post_rst_sync2");
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
